// File: rtl/binary_down_counter.sv
// Loadable down-counter/timer with IDLE/RUN/DONE control and a one-cycle terminal-count pulse.
// Define DOWN_COUNTER_RELOAD_EN for auto-reload (periodic tc); the default build is one-shot.
module binary_down_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] start_val,
    input  logic             en,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic [WIDTH-1:0] reload_reg, reload_next;
    logic             tc_reg, tc_next;
    logic             busy_reg, done_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            reload_reg <= '0;
            tc_reg     <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            reload_reg <= reload_next;
            tc_reg     <= tc_next;
            busy_reg   <= (state_next == RUN);
            done_reg   <= (state_next == DONE);
        end
    end

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        reload_next = reload_reg;
        tc_next     = 1'b0;

        if (abort) begin
            state_next = IDLE;
            count_next = '0;
        end else if (start) begin
            if (start_val != '0) begin
                count_next  = start_val;
                reload_next = start_val;
                state_next  = RUN;
            end else begin
                // A zero load is already expired: go straight to DONE with a tc pulse.
                count_next = '0;
                state_next = DONE;
                tc_next    = 1'b1;
            end
        end else if (state_reg == RUN && en) begin
            if (count_reg > WIDTH'(1)) begin
                count_next = count_reg - WIDTH'(1);
            end else if (count_reg == WIDTH'(1)) begin
                count_next = '0;
                tc_next    = 1'b1;
`ifdef DOWN_COUNTER_RELOAD_EN
                state_next = RUN;
`else
                state_next = DONE;
`endif
            end else begin
`ifdef DOWN_COUNTER_RELOAD_EN
                // Count rests at 0 for one enabled cycle after tc, then reloads.
                count_next = reload_reg;
`else
                count_next = count_reg;
`endif
            end
        end
    end

    assign count = count_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;
    assign tc    = tc_reg;

endmodule

// File: tb/tb_binary_down_counter.sv
// Scoreboard bench for binary_down_counter: a driver pushes model predictions, a monitor pops and compares.
module tb_binary_down_counter;

    localparam int WIDTH = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] start_val = '0;
    logic             en = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] count;
    logic             busy, done, tc;

    binary_down_counter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .start_val(start_val),
        .en(en), .abort(abort), .count(count), .busy(busy), .done(done), .tc(tc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int count;
        bit busy;
        bit done;
        bit tc;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad = 0;
    int txn = 0;

    // Reference model: 0=idle, 1=running, 2=finished; remaining time kept as a plain integer.
    int m_phase = 0;
    int m_left = 0;
    int m_period = 0;
    bit m_tc = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        m_phase = 0; m_left = 0; m_period = 0; m_tc = 0;
    endfunction

    function automatic void model_step(input bit s, input int sv, input bit e, input bit a);
        m_tc = 0;
        if (a) begin
            m_phase = 0; m_left = 0;
        end else if (s) begin
            m_left = sv;
            if (sv == 0) begin
                m_phase = 2; m_tc = 1;
            end else begin
                m_phase = 1; m_period = sv;
            end
        end else if (m_phase == 1 && e) begin
            if (m_left == 0) begin
                m_left = m_period;
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_tc = 1;
`ifndef DOWN_COUNTER_RELOAD_EN
                    m_phase = 2;
`endif
                end
            end
        end
    endfunction

    task automatic step(input bit s, input int sv, input bit e, input bit a);
        exp_t x;
        @(negedge clk);
        start = s; start_val = WIDTH'(sv); en = e; abort = a;
        model_step(s, sv, e, a);
        x.count = m_left; x.busy = (m_phase == 1); x.done = (m_phase == 2); x.tc = m_tc;
        exp_q.push_back(x);
    endtask

    // Monitor: outputs are presented every cycle; compare after each active edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            txn++;
            $display("txn %0d: count=%0d busy=%0d done=%0d tc=%0d (model %0d/%0d/%0d/%0d)",
                     txn, count, busy, done, tc, x.count, x.busy, x.done, x.tc);
            chk("count", int'(count), x.count);
            chk("busy", int'(busy), int'(x.busy));
            chk("done", int'(done), int'(x.done));
            chk("tc", int'(tc), int'(x.tc));
        end
    end

    task automatic chk_cleared(input string tag);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_tc"}, int'(tc), 0);
    endtask

    initial begin
        int waited;
        // Reset held while start is driven: outputs must stay cleared.
        rst = 1'b0; start = 1'b1; start_val = 6'd5; en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_cleared("reset");
        @(negedge clk);
        rst = 1'b1; start = 1'b0; en = 1'b0;
        model_reset();
        repeat (3) step(0, 0, 0, 0);

        // One-shot run with en held high, then linger in DONE.
        step(1, 5, 1, 0);
        repeat (5) step(0, 0, 1, 0);
        repeat (10) step(0, 0, ($urandom_range(0, 1) == 1), 0);

        // Enable gating.
        step(1, 3, 0, 0);
        step(0, 0, 1, 0); step(0, 0, 0, 0); step(0, 0, 1, 0);
        step(0, 0, 0, 0); step(0, 0, 1, 0); step(0, 0, 0, 0);

        // Priority: restart at count 1, then abort beats start at count 1.
        step(1, 2, 0, 0); step(0, 0, 1, 0);
        step(1, 4, 1, 0);
        repeat (3) step(0, 0, 1, 0);
        step(1, 4, 1, 1);
        step(0, 0, 1, 0);

        // Zero load.
        step(1, 0, 1, 0);
        repeat (2) step(0, 0, 1, 0);

`ifdef DOWN_COUNTER_RELOAD_EN
        step(1, 3, 1, 0);
        repeat (12) step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        step(0, 0, 1, 0);
`endif

        // Asynchronous reset in the middle of a run.
        step(1, 9, 1, 0);
        repeat (3) step(0, 0, 1, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk_cleared("async_reset");
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        step(0, 0, 1, 0);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            bit s, a, e;
            int sv;
            s  = ($urandom_range(0, 7) == 0);
            a  = ($urandom_range(0, 15) == 0);
            e  = ($urandom_range(0, 3) != 0);
            sv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 12));
            step(s, sv, e, a);
        end

        step(0, 0, 0, 0);
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
